// File: rtl/rr_priority_encoder_n_if.sv
// rr_priority_encoder_n_if
// Bundles the request side and the code/valid/ready side of the round-robin
// encoder into one interface.
//   master : drives req, enabler, out_ready; observes valid, code, ack
//            (and overflow when ENC_OVERFLOW_EN is defined)
//   slave  : the encoder itself
// Optional macro: ENC_OVERFLOW_EN adds the sticky overflow signal.
interface rr_priority_encoder_n_if #(
  parameter int N = 3
);
  localparam int M = 1 << N;

  logic [M-1:0] req;        // 1 on bit i marks source i pending
  logic         enabler;    // 0 freezes new selections
  logic         out_ready;  // consumer accepts the code this cycle
  logic         valid;      // code is valid
  logic [N-1:0] code;       // index of the granted source
  logic [M-1:0] ack;        // one-hot of code on a transfer
`ifdef ENC_OVERFLOW_EN
  logic         overflow;   // sticky: an event merged into an unserved one

  modport master (output req, enabler, out_ready,
                  input  valid, code, ack, overflow);
  modport slave  (input  req, enabler, out_ready,
                  output valid, code, ack, overflow);
`else
  modport master (output req, enabler, out_ready,
                  input  valid, code, ack);
  modport slave  (input  req, enabler, out_ready,
                  output valid, code, ack);
`endif
endinterface

// File: rtl/rr_priority_encoder_n.sv
// rr_priority_encoder_n
// Collects 2**N request lines into sticky pending bits and hands out one
// binary source index per accepted transfer, round-robin from a pointer that
// advances past each served code. Output is a valid/ready register; ack is
// the one-hot of the code qualified by the transfer.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : rr_priority_encoder_n_if.slave (req, enabler, out_ready in;
//           valid, code, ack [, overflow] out)
// Optional macro: ENC_OVERFLOW_EN enables the sticky overflow flag.

// Per-source bookkeeping: pending update, candidate qualification and
// (optionally) merged-event detection for one request line.
module rr_priority_encoder_n_lane (
  input  logic pend_q,
  input  logic ack,
  input  logic req,
  output logic pend_d,
  output logic cand
`ifdef ENC_OVERFLOW_EN
  ,
  output logic merge
`endif
);
  // Candidate uses registered state only; a same-cycle req is not eligible.
  assign cand   = pend_q & ~ack;
  // A req on the bit being acked re-arms it as a fresh event.
  assign pend_d = cand | req;
`ifdef ENC_OVERFLOW_EN
  // New event landing on a source that is still waiting for service.
  assign merge  = req & cand;
`endif
endmodule

module rr_priority_encoder_n #(
  parameter int N = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  rr_priority_encoder_n_if.slave bus
);
  localparam int M = 1 << N;

  logic [M-1:0] pending_q, pending_d;
  logic         valid_q, valid_d;
  logic [N-1:0] code_q, code_d;
  logic [N-1:0] ptr_q, ptr_d;

  logic         xfer;
  logic         load;
  logic [M-1:0] ack;
  logic [M-1:0] cand;
  logic [M-1:0] rot;
  logic [N-1:0] off;
  logic [N-1:0] winner;
  logic         found;

`ifdef ENC_OVERFLOW_EN
  logic [M-1:0] merge;
  logic         overflow_q, overflow_d;
`endif

  // Transfer and acknowledge come straight from the output register and
  // out_ready, so ack is valid in the same cycle as the handshake.
  always_comb begin
    xfer = valid_q & bus.out_ready;
    ack  = '0;
    if (xfer) ack[code_q] = 1'b1;
  end

  for (genvar i = 0; i < M; i++) begin : g_lane
    rr_priority_encoder_n_lane u_lane (
      .pend_q (pending_q[i]),
      .ack    (ack[i]),
      .req    (bus.req[i]),
      .pend_d (pending_d[i]),
      .cand   (cand[i])
`ifdef ENC_OVERFLOW_EN
      ,
      .merge  (merge[i])
`endif
    );
  end

  // Round-robin search: rotate candidates so ptr lands at bit 0, take the
  // lowest set bit, then add ptr back (N-bit add wraps modulo 2**N).
  always_comb begin
    rot = '0;
    for (int i = 0; i < M; i++) begin
      rot[i] = cand[ptr_q + N'(i)];
    end
    off = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (rot[i]) off = N'(i);
    end
    winner = ptr_q + off;
    found  = |cand;
  end

  // Output register: only reloads when empty or being drained this cycle,
  // so a held code stays stable until accepted regardless of enabler.
  always_comb begin
    load    = ~valid_q | xfer;
    valid_d = valid_q;
    code_d  = code_q;
    if (load) begin
      valid_d = 1'b0;
      if (bus.enabler && found) begin
        valid_d = 1'b1;
        code_d  = winner;
      end
    end
    ptr_d = xfer ? code_q + N'(1) : ptr_q;
  end

`ifdef ENC_OVERFLOW_EN
  always_comb begin
    overflow_d = overflow_q | (|merge);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      ptr_q     <= '0;
`ifdef ENC_OVERFLOW_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
`ifdef ENC_OVERFLOW_EN
      overflow_q <= overflow_d;
`endif
    end
  end

  assign bus.valid = valid_q;
  assign bus.code  = code_q;
  assign bus.ack   = ack;
`ifdef ENC_OVERFLOW_EN
  assign bus.overflow = overflow_q;
`endif

endmodule
